split_slave_port: RTL and testbench
===================================

# split_slave_port

Slave-side bus port that answers master transactions routed by the address decoder and drives the `sready` / `ssplit` handshake consumed by the two-master arbiter. It completes reads and writes against a variable-latency memory. A read that misses the `SPLIT_WAIT` deadline is split: the port releases the bus, finishes the access in the background, then requests the bus back through `split_req` / `split_grant` to return the data. One outstanding split per port; one instance per slave.

## Interface
- `ADDR_WIDTH`, 12, slave-local address width.
- `DATA_WIDTH`, 8, data width.
- `SPLIT_WAIT`, 4, memory-wait cycles tolerated before a read is split (≥1).

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `ssel` in 1: decoder select for this slave.
- `mvalid` in 1: master request valid.
- `mwen` in 1: 1 = write, 0 = read.
- `maddr` in `ADDR_WIDTH`: request address.
- `mwdata` in `DATA_WIDTH`: write data.
- `srdata` out `DATA_WIDTH`: read data, valid with `srvalid`.
- `srvalid` out 1: one-cycle read-data strobe.
- `serr` out 1: one-cycle reject strobe; the request was dropped.
- `sready` out 1: slave ready, to the arbiter.
- `ssplit` out 1: one-cycle split pulse, to the arbiter.
- `split_req` out 1: split data ready; bus requested back.
- `split_grant` in 1: arbiter permission to finish the split transaction.
- `mem_req` out 1: memory access request, held until `mem_ack`.
- `mem_wen` out 1: memory write enable.
- `mem_addr` out `ADDR_WIDTH`: memory address.
- `mem_wdata` out `DATA_WIDTH`: memory write data.
- `mem_rdata` in `DATA_WIDTH`: memory read data, valid with `mem_ack`.
- `mem_ack` in 1: one-cycle access completion.

## Operation
States: IDLE, ACCESS, RESPOND, SPLIT, BG_READ, RESUME.

- **IDLE** (`sready`=1)
  - `ssel & mvalid` latches `mwen`, `maddr`, `mwdata` into the request registers.
  - Clears the wait counter and moves to ACCESS.
- **ACCESS** (`sready`=0, `mem_req`=1; `mem_*` driven from the latched request)
  - `mem_ack` on a write → IDLE.
  - `mem_ack` on a read → latch `mem_rdata` → RESPOND.
  - Read with no ack: the wait counter increments each cycle. When the counter equals `SPLIT_WAIT`-1 with no ack → SPLIT.
  - `mem_ack` has priority over the split decision on the same edge.
  - Writes never split; they wait indefinitely.
- **RESPOND** (`srvalid`=1, `srdata`=latched data, `sready`=0, `mem_req`=0) → IDLE after one cycle.
- **SPLIT** (`ssplit`=1, `sready`=1, `mem_req`=1)
  - Lasts exactly one cycle.
  - `mem_ack` here latches the data → RESUME; otherwise → BG_READ.
- **BG_READ** (`sready`=1, `mem_req`=1): `mem_ack` latches the data → RESUME.
- **RESUME** (`sready`=1, `split_req`=1, `mem_req`=0)
  - Holds until `split_grant` is sampled high → RESPOND.
  - `split_req` drops as RESPOND begins.
- **Reject rule**: in SPLIT, BG_READ or RESUME, a sampled `ssel & mvalid` produces `serr`=1 for the next cycle only. The request is discarded, with no memory access and no state change.
- **Ignored inputs**
  - `split_grant` is ignored outside RESUME.
  - `ssel` / `mvalid` are ignored in ACCESS and RESPOND.
- **Counter width**: the wait counter is clog2(`SPLIT_WAIT`)+1 bits and saturates; it never wraps.

## Timing
- Reset values:
  - state IDLE; `sready`=1.
  - `ssplit`, `split_req`, `srvalid`, `serr`, `mem_req`, `mem_wen` = 0.
  - `srdata`, `mem_addr`, `mem_wdata` = 0; counter 0.
- Reset mid-operation aborts any access, including a pending split. The memory must tolerate `mem_req` dropping before `mem_ack`.
- Request sampled at edge T: from cycle T+1, `sready`=0 and `mem_req`=1.
- `mem_ack` sampled at edge A on a read: `srvalid`=1 during cycle A+1, then `sready`=1 from A+2.
- `mem_ack` sampled at edge A on a write: `sready`=1 and `mem_req`=0 from A+1.
- No-ack read: `ssplit` is high during cycle T+1+`SPLIT_WAIT`, i.e. after exactly `SPLIT_WAIT` cycles of `mem_req` in ACCESS.
- `split_req` rises in the cycle after the background ack.
- `split_grant` sampled at edge G: `srvalid`=1 during cycle G+1, `split_req`=0 in that same cycle, IDLE at G+2.
- All outputs are registered or decoded from state only; there is no combinational input-to-output path.

## Test plan
1. **Fast read**: `SPLIT_WAIT`=4; read `maddr`=0x010; `mem_ack` with `mem_rdata`=0xA5 two cycles after `mem_req` rises → `srvalid`=1 with `srdata`=0xA5 for one cycle, `ssplit` never high, `sready` returns to 1.
2. **Slow write**: write 0x3C to 0x020 with ack after 10 cycles → `mem_wen`=1, `mem_wdata`=0x3C held 10 cycles, no `ssplit`, `sready`=1 in the cycle after ack.
3. **Split read**: read 0x044 with ack after 9 cycles, `mem_rdata`=0x5A → `ssplit` one-cycle pulse exactly 4 cycles after `mem_req` rises; `split_req`=1 the cycle after ack; `split_grant` 3 cycles later → `srvalid` with 0x5A one cycle after grant, `split_req`=0.
4. **Boundary ack**:
   - Ack on the deciding edge (`mem_req` cycle 4) → no split.
   - Ack during the SPLIT cycle → skip BG_READ, `split_req` next cycle.
5. **Reject while split**: during BG_READ, issue another read to this slave → `serr`=1 one cycle later, no extra `mem_req`. The original split still completes with the correct data.
6. **Reset mid-split**: assert `rstn`=0 during RESUME → next cycle `split_req`=0, `sready`=1, state IDLE. A following fast read completes normally.

Source files
------------

// File: rtl/split_slave_port.sv
// Slave-side bus port: completes reads/writes against a variable-latency memory and
// splits slow reads, releasing the bus and requesting it back once the data is in hand.
module split_slave_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int SPLIT_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ssel,
  input  logic                  mvalid,
  input  logic                  mwen,
  input  logic [ADDR_WIDTH-1:0] maddr,
  input  logic [DATA_WIDTH-1:0] mwdata,
  output logic [DATA_WIDTH-1:0] srdata,
  output logic                  srvalid,
  output logic                  serr,
  output logic                  sready,
  output logic                  ssplit,
  output logic                  split_req,
  input  logic                  split_grant,
  output logic                  mem_req,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam int CW = $clog2(SPLIT_WAIT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SPLIT_WAIT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {IDLE, ACCESS, RESPOND, SPLIT, BG_READ, RESUME} state_t;

  typedef struct packed {
    logic                  wen;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  req_t                  req_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  serr_q;
  logic                  req_hit, bg_busy, latch_req, latch_rdata;

  assign req_hit = ssel & mvalid;
  assign bg_busy = (state == SPLIT) || (state == BG_READ) || (state == RESUME);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    latch_req   = 1'b0;
    latch_rdata = 1'b0;
    case (state)
      IDLE: if (req_hit) begin
        latch_req = 1'b1;
        cnt_nxt   = '0;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        // ack wins over the split decision taken on the same edge
        if (mem_ack) begin
          if (req_q.wen) state_nxt = IDLE;
          else begin
            latch_rdata = 1'b1;
            state_nxt   = RESPOND;
          end
        end else if (!req_q.wen && cnt == CNT_LAST) begin
          state_nxt = SPLIT;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RESPOND: state_nxt = IDLE;
      SPLIT: begin
        if (mem_ack) begin
          latch_rdata = 1'b1;
          state_nxt   = RESUME;
        end else begin
          state_nxt = BG_READ;
        end
      end
      BG_READ: if (mem_ack) begin
        latch_rdata = 1'b1;
        state_nxt   = RESUME;
      end
      RESUME: if (split_grant) state_nxt = RESPOND;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      serr_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      // requests arriving while a split is in flight are dropped with a strobe
      serr_q <= bg_busy & req_hit;
      if (latch_req) begin
        req_q.wen   <= mwen;
        req_q.addr  <= maddr;
        req_q.wdata <= mwdata;
      end
      if (latch_rdata) rdata_q <= mem_rdata;
    end
  end

  assign sready    = (state == IDLE) || bg_busy;
  assign mem_req   = (state == ACCESS) || (state == SPLIT) || (state == BG_READ);
  assign mem_wen   = req_q.wen & (state == ACCESS);
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign srdata    = rdata_q;
  assign srvalid   = (state == RESPOND);
  assign ssplit    = (state == SPLIT);
  assign split_req = (state == RESUME);
  assign serr      = serr_q;

endmodule

// File: tb/tb_split_slave_port.sv
// Bench for split_slave_port: a latency-programmable memory responder plus a
// cycle-timeline model derived from each transaction's latency and grant delay.
module tb_split_slave_port;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          ssel = 1'b0, mvalid = 1'b0, mwen = 1'b0, split_grant = 1'b0;
  logic [AW-1:0] maddr = '0;
  logic [DW-1:0] mwdata = '0;
  logic [DW-1:0] srdata;
  logic          srvalid, serr, sready, ssplit, split_req;
  logic          mem_req, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mem [0:4095];
  logic [DW-1:0] mdl [0:4095];
  int mem_lat = 1;
  int rsp_cnt = 0;

  split_slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SPLIT_WAIT(SW)) dut (
    .clk(clk), .rstn(rstn), .ssel(ssel), .mvalid(mvalid), .mwen(mwen), .maddr(maddr),
    .mwdata(mwdata), .srdata(srdata), .srvalid(srvalid), .serr(serr), .sready(sready),
    .ssplit(ssplit), .split_req(split_req), .split_grant(split_grant), .mem_req(mem_req),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Memory: acks at the end of the mem_lat-th consecutive mem_req cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req && rstn) begin
        rsp_cnt++;
        if (rsp_cnt == mem_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          if (mem_wen) mem[mem_addr] = mem_wdata;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = DW'($urandom);
        end
      end else begin
        rsp_cnt   = 0;
        mem_ack   = 1'b0;
        mem_rdata = DW'($urandom);
      end
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem[a] = d;
    mdl[a] = d;
  endtask

  // One transaction from the IDLE cycle it is issued in to the IDLE cycle after it completes.
  task automatic drive_txn(input logic wen, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input int lat, input int gd, input int rej);
    logic split;
    int k, last;
    logic e_sready, e_srvalid, e_ssplit, e_sreq, e_serr, e_mreq, e_mwen;
    logic [6:0] exp_v, act_v;
    logic [DW-1:0] exp_d;
    split = !wen && lat > SW;
    k     = lat + 1 + gd;
    last  = split ? k + 2 : (wen ? lat + 1 : lat + 2);
    exp_d = mdl[addr];
    mem_lat = lat;
    ssel = 1'b1; mvalid = 1'b1; mwen = wen; maddr = addr; mwdata = wd; split_grant = 1'b0;
    @(posedge clk); #1;
    for (int c = 1; c <= last; c++) begin
      e_mreq    = c <= lat;
      e_mwen    = wen && c <= lat;
      e_ssplit  = split && c == SW + 1;
      e_sreq    = split && c > lat && c <= k;
      e_srvalid = split ? (c == k + 1) : (!wen && c == lat + 1);
      e_sready  = split ? ((c > SW && c <= k) || c == last) : (c == last);
      e_serr    = split && rej > 0 && c == rej + 1;
      exp_v = {e_sready, e_srvalid, e_ssplit, e_sreq, e_serr, e_mreq, e_mwen};
      act_v = {sready, srvalid, ssplit, split_req, serr, mem_req, mem_wen};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL status addr=%h cycle %0d got %b want %b (sready,srvalid,ssplit,split_req,serr,mem_req,mem_wen)",
                 addr, c, act_v, exp_v);
      end
      if (e_mreq) begin
        checks++;
        if (mem_addr !== addr || (wen && mem_wdata !== wd)) begin
          errors++;
          $display("FAIL mem_bus cycle %0d got addr=%h wdata=%h want addr=%h wdata=%h",
                   c, mem_addr, mem_wdata, addr, wd);
        end
      end
      if (e_srvalid) begin
        checks++;
        if (srdata !== exp_d) begin
          errors++;
          $display("FAIL srdata addr=%h got %h want %h", addr, srdata, exp_d);
        end
      end
      if (c == last) begin
        ssel = 1'b0; mvalid = 1'b0; split_grant = 1'b0;
      end else begin
        // Noise on inputs the port must ignore in its current phase
        ssel   = 1'($urandom);
        mwen   = 1'($urandom);
        maddr  = AW'($urandom);
        mwdata = DW'($urandom);
        mvalid = e_sready ? (split && c == rej) : 1'($urandom);
        if (split && c == rej) ssel = 1'b1;
        split_grant = (split && c > lat && c <= k) ? (c == k) : 1'($urandom);
        @(posedge clk); #1;
      end
    end
    if (wen) mdl[addr] = wd;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({sready, srvalid, ssplit, split_req, serr, mem_req, mem_wen} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 1000000",
               {sready, srvalid, ssplit, split_req, serr, mem_req, mem_wen});
    end
    checks++;
    if (srdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_data got srdata=%h mem_addr=%h mem_wdata=%h want 0", srdata, mem_addr, mem_wdata);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fast_read;
    preload(12'h010, 8'hA5);
    drive_txn(1'b0, 12'h010, 8'h00, 2, 0, 0);
  endtask

  task automatic test_slow_write;
    drive_txn(1'b1, 12'h020, 8'h3C, 10, 0, 0);
    drive_txn(1'b0, 12'h020, 8'h00, 1, 0, 0);
  endtask

  task automatic test_split_read;
    preload(12'h044, 8'h5A);
    drive_txn(1'b0, 12'h044, 8'h00, 9, 3, 0);
  endtask

  task automatic test_boundary_ack;
    preload(12'h050, 8'h11);
    preload(12'h051, 8'h22);
    drive_txn(1'b0, 12'h050, 8'h00, SW, 0, 0);
    drive_txn(1'b0, 12'h051, 8'h00, SW + 1, 1, 0);
  endtask

  task automatic test_reject_split;
    preload(12'h060, 8'hC3);
    drive_txn(1'b0, 12'h060, 8'h00, 8, 2, SW + 2);
    drive_txn(1'b0, 12'h060, 8'h00, 6, 3, 8);
  endtask

  task automatic test_reset_mid_split;
    int n;
    preload(12'h0AB, 8'h9D);
    mem_lat = SW + 3;
    ssel = 1'b1; mvalid = 1'b1; mwen = 1'b0; maddr = 12'h0AB; split_grant = 1'b0;
    @(posedge clk); #1;
    ssel = 1'b0; mvalid = 1'b0;
    n = 0;
    while (split_req !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (split_req !== 1'b1) begin
      errors++;
      $display("FAIL resume_timeout got split_req=%b want 1 within 40 cycles", split_req);
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({sready, srvalid, ssplit, split_req, mem_req} !== 5'b10000) begin
        errors++;
        $display("FAIL reset_mid_split cycle %0d got %b want 10000 (sready,srvalid,ssplit,split_req,mem_req)",
                 i, {sready, srvalid, ssplit, split_req, mem_req});
      end
      @(posedge clk); #1;
    end
    drive_txn(1'b0, 12'h0AB, 8'h00, 2, 0, 0);
  endtask

  task automatic test_random;
    logic wen, split;
    logic [AW-1:0] a;
    int lat, gd, rej;
    for (int t = 0; t < 40; t++) begin
      wen   = ($urandom_range(0, 2) == 0);
      a     = AW'($urandom_range(0, 31));
      lat   = $urandom_range(1, 12);
      gd    = $urandom_range(0, 4);
      split = !wen && lat > SW;
      rej   = (split && $urandom_range(0, 1) == 1) ? $urandom_range(SW + 1, lat + 1 + gd) : 0;
      drive_txn(wen, a, DW'($urandom), lat, gd, rej);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = DW'($urandom);
      mdl[i] = mem[i];
    end
    test_reset();
    test_fast_read();
    test_slow_write();
    test_split_read();
    test_boundary_ack();
    test_reject_split();
    test_reset_mid_split();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
